// File: rtl/axi_lite_sram_slave.sv
// AXI-lite responder backed by a word-addressed SRAM array.
// One transaction at a time, with a programmable response delay.
module axi_lite_sram_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [32:0]   SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [CW-1:0] LAT  = CW'(LATENCY);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_DELAY,
    RD_RESP,
    WR_COLLECT,
    WR_DELAY,
    WR_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          bvalid_q, bvalid_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          mem_we;
  logic          aw_hs;
  logic          w_hs;
  logic          unused_bits;

  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx      = off[AW+1:2];
  assign unused_bits = ^{wstrb[7:4], off};

  assign arready = (state_q == IDLE);
  assign awready = ((state_q == IDLE) && !arvalid) ||
                   ((state_q == WR_COLLECT) && !aw_got_q);
  assign wready  = ((state_q == IDLE) && !arvalid) ||
                   ((state_q == WR_COLLECT) && !w_got_q);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

  // Commit is suppressed under reset so an abandoned write never lands.
  assign mem_we = (state_q == WR_DELAY) && (cnt_q == '0) &&
                  in_range && !rst;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    case (state_q)
      IDLE, WR_COLLECT: begin
        if (state_q == IDLE && arvalid) begin
          addr_d  = araddr;
          cnt_d   = LAT;
          state_d = RD_DELAY;
        end else begin
          if (aw_hs) begin
            addr_d   = awaddr;
            aw_got_d = 1'b1;
          end
          if (w_hs) begin
            wdata_d = wdata;
            wstrb_d = wstrb[3:0];
            w_got_d = 1'b1;
          end
          if (aw_got_d && w_got_d) begin
            cnt_d   = LAT;
            state_d = WR_DELAY;
          end else if (aw_got_d || w_got_d) begin
            state_d = WR_COLLECT;
          end
        end
      end
      RD_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d  = in_range ? mem[idx] : 32'h0;
          rresp_d  = in_range ? OKAY : DECERR;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          bresp_d  = in_range ? OKAY : DECERR;
          bvalid_d = 1'b1;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rvalid_q <= 1'b0;
      bresp_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
